// File: rtl/invgate_checker.sv
// Response checker for a single-bit inverter gate. Captures the stimulus bit on
// sample_valid_i, waits SETTLE cycles, then checks b_in_i against the inverted
// capture. Reports pass/fail once NUM_SAMPLES comparisons have been made.
`timescale 1ns/1ps

module invgate_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned SETTLE      = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sample_valid_i,
  input  logic             a_in_i,
  input  logic             b_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] sample_count_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             first_err_seen_o,
  output logic [CNT_W-1:0] first_err_idx_o
);

  // Settle counter only needs to hold SETTLE; keep at least one bit for SETTLE=0.
  localparam int unsigned SetW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE);
  localparam logic [SetW-1:0]  SettleLast = SetW'(1);
  localparam logic [CNT_W-1:0] NumSamples = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSettle,
    StCompare,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              a_cap_q, a_cap_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              first_err_seen_q, first_err_seen_d;
  logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
  logic              mismatch;
  logic [CNT_W-1:0]  sample_inc;

  // Next-state logic: sequencing, capture, settle countdown and result update.
  always_comb begin
    state_d          = state_q;
    a_cap_d          = a_cap_q;
    settle_d         = settle_q;
    sample_count_d   = sample_count_q;
    err_count_d      = err_count_q;
    first_err_seen_d = first_err_seen_q;
    first_err_idx_d  = first_err_idx_q;
    sample_inc       = sample_count_q + 1'b1;

    // Written so an unknown b_in_i falls through to a mismatch in 4-state sim.
    mismatch = 1'b1;
    if (b_in_i == ~a_cap_q) begin
      mismatch = 1'b0;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d          = StWait;
          sample_count_d   = '0;
          err_count_d      = '0;
          first_err_seen_d = 1'b0;
          first_err_idx_d  = '0;
        end
      end
      StWait: begin
        if (sample_valid_i) begin
          a_cap_d  = a_in_i;
          settle_d = SettleLoad;
          state_d  = (SETTLE == 0) ? StCompare : StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SettleLast) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (mismatch) begin
          if (err_count_q != CntMax) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!first_err_seen_q) begin
            first_err_seen_d = 1'b1;
            first_err_idx_d  = sample_count_q;
          end
        end
        sample_count_d = sample_inc;
        state_d        = (sample_inc == NumSamples) ? StDone : StWait;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      a_cap_q          <= 1'b0;
      settle_q         <= '0;
      sample_count_q   <= '0;
      err_count_q      <= '0;
      first_err_seen_q <= 1'b0;
      first_err_idx_q  <= '0;
    end else begin
      state_q          <= state_d;
      a_cap_q          <= a_cap_d;
      settle_q         <= settle_d;
      sample_count_q   <= sample_count_d;
      err_count_q      <= err_count_d;
      first_err_seen_q <= first_err_seen_d;
      first_err_idx_q  <= first_err_idx_d;
    end
  end

  assign busy_o           = (state_q == StWait) || (state_q == StSettle) ||
                            (state_q == StCompare);
  assign done_o           = (state_q == StDone);
  assign pass_o           = (state_q == StDone) && (err_count_q == '0);
  assign sample_count_o   = sample_count_q;
  assign err_count_o      = err_count_q;
  assign first_err_seen_o = first_err_seen_q;
  assign first_err_idx_o  = first_err_idx_q;

endmodule
